// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: VGA raster timing with an on-chip pixel framebuffer, clear engine
// and frame/blank status. Everything runs on clk; pix_ce sets the pixel rate.
module vga_fb_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BPP      = 3,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOT),
    localparam int YW      = $clog2(V_TOT),
    localparam int N       = H_ACTIVE * V_ACTIVE,
    localparam int AW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           pix_ce,
    input  logic           wr_en,
    input  logic [XW-1:0]  wr_x,
    input  logic [YW-1:0]  wr_y,
    input  logic [BPP-1:0] wr_pixel,
    output logic           wr_ready,
    input  logic           clr_start,
    input  logic [BPP-1:0] clr_color,
    output logic           clr_busy,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [BPP-1:0] rgb,
    output logic           vblank,
    output logic           frame_start
);

    localparam logic [XW-1:0] H_LAST = XW'(H_TOT - 1);
    localparam logic [XW-1:0] H_VIS  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOT - 1);
    localparam logic [YW-1:0] V_VIS  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);
    localparam logic [AW-1:0] A_HACT = AW'(H_ACTIVE);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    logic [XW-1:0]  h;
    logic [YW-1:0]  v;
    logic           vis0, hs0, vs0;
    logic [AW-1:0]  rd_addr;
    logic           vis1, hs1, vs1;
    logic [BPP-1:0] ram_q;
    logic [BPP-1:0] mem [N];

    clr_state_t     clr_state;
    logic [AW-1:0]  clr_addr;
    logic [BPP-1:0] clr_val;

    logic           ram_we;
    logic [AW-1:0]  ram_wa;
    logic [BPP-1:0] ram_wd;
    logic           wr_in_range;

    assign vis0     = (h < H_VIS) && (v < V_VIS);
    assign hs0      = (h >= HS_BEG) && (h < HS_END);
    assign vs0      = (v >= VS_BEG) && (v < VS_END);
    assign rd_addr  = AW'(v) * A_HACT + AW'(h);
    assign vblank   = (v >= V_VIS);
    assign wr_ready = !clr_busy;

    assign wr_in_range = (wr_x < H_VIS) && (wr_y < V_VIS);

    // Raster counters: h advances per pixel tick, v per line; both wrap.
    always_ff @(posedge clk) begin
        if (srst) begin
            h <= '0;
            v <= '0;
        end else if (pix_ce) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + YW'(1);
            end else begin
                h <= h + XW'(1);
            end
        end
    end

    // One-clock pulse on the tick that wraps the raster back to (0,0).
    always_ff @(posedge clk) begin
        if (srst) frame_start <= 1'b0;
        else      frame_start <= pix_ce && (h == H_LAST) && (v == V_LAST);
    end

    // Stage 1 control: delay visibility/sync flags alongside the RAM read.
    always_ff @(posedge clk) begin
        if (srst) begin
            vis1 <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
        end else if (pix_ce) begin
            vis1 <= vis0;
            hs1  <= hs0;
            vs1  <= vs0;
        end
    end

    // Registered framebuffer read port; kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (pix_ce && vis0) ram_q <= mem[rd_addr];
    end

    // Stage 2: drive the pins; rgb is forced to 0 outside the visible area.
    always_ff @(posedge clk) begin
        if (srst) begin
            rgb   <= '0;
            de    <= 1'b0;
            hsync <= !HS_POL;
            vsync <= !VS_POL;
        end else if (pix_ce) begin
            rgb   <= vis1 ? ram_q : '0;
            de    <= vis1;
            hsync <= hs1 ? HS_POL : !HS_POL;
            vsync <= vs1 ? VS_POL : !VS_POL;
        end
    end

    // Write-port arbitration: the clear engine owns the port while busy.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = '0;
        ram_wd = '0;
        if (clr_state == CLEAR) begin
            ram_we = 1'b1;
            ram_wa = clr_addr;
            ram_wd = clr_val;
        end else if (wr_en && wr_in_range) begin
            ram_we = 1'b1;
            ram_wa = AW'(wr_y) * A_HACT + AW'(wr_x);
            ram_wd = wr_pixel;
        end
    end

    // Framebuffer write port; reset blocks the write so an aborted clear stops cleanly.
    always_ff @(posedge clk) begin
        if (ram_we && !srst) mem[ram_wa] <= ram_wd;
    end

    // Clear engine: sweeps every address once, one word per clock.
    always_ff @(posedge clk) begin
        if (srst) begin
            clr_state <= IDLE;
            clr_busy  <= 1'b0;
            clr_addr  <= '0;
            clr_val   <= '0;
        end else begin
            case (clr_state)
                IDLE: begin
                    if (clr_start) begin
                        clr_state <= CLEAR;
                        clr_busy  <= 1'b1;
                        clr_addr  <= '0;
                        clr_val   <= clr_color;
                    end
                end
                CLEAR: begin
                    if (clr_addr == A_LAST) begin
                        clr_state <= IDLE;
                        clr_busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                default: begin
                    clr_state <= IDLE;
                    clr_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// tb_vga_fb_ctrl: small-geometry bench for vga_fb_ctrl. A behavioural raster and
// framebuffer model predicts every output each clock; directed phases add
// hand-computed checks on frame period, sync widths and framebuffer contents.
module tb_vga_fb_ctrl;

    localparam int HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 12
    localparam int VT = VA + VF + VS + VB;   // 8
    localparam int N  = HA * VA;             // 32

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       pix_ce = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_x = '0;
    logic [2:0] wr_y = '0;
    logic [2:0] wr_pixel = '0;
    logic       wr_ready;
    logic       clr_start = 1'b0;
    logic [2:0] clr_color = '0;
    logic       clr_busy;
    logic       hsync, vsync, de, vblank, frame_start;
    logic [2:0] rgb;

    vga_fb_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BPP(3), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .srst(srst), .pix_ce(pix_ce),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel), .wr_ready(wr_ready),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .vblank(vblank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit       vis;
        bit       hs;
        bit       vs;
        bit       known;
        bit [2:0] pix;
    } exp_t;

    exp_t     e_rd, e_out, cur;
    int       mh = 0, mv = 0;
    bit       m_fs = 0;
    int       m_clr_left = 0, m_clr_addr = 0;
    bit [2:0] m_clr_val = 0;
    bit [2:0] fb [N];
    bit       fb_ok [N];
    bit       m_we;
    int       m_wa, m_ra;
    bit [2:0] m_wd;

    always @(posedge clk) begin
        if (srst) begin
            mh = 0; mv = 0; m_fs = 0; m_clr_left = 0;
            e_rd = '{default: 0};
            e_out = '{default: 0};
        end else begin
            m_we = 0; m_wa = 0; m_wd = 0;
            if (m_clr_left > 0) begin
                m_we = 1; m_wa = m_clr_addr; m_wd = m_clr_val;
                m_clr_addr++; m_clr_left--;
            end else begin
                if (clr_start) begin
                    m_clr_left = N; m_clr_addr = 0; m_clr_val = clr_color;
                end
                if (wr_en && int'(wr_x) < HA && int'(wr_y) < VA) begin
                    m_we = 1; m_wa = int'(wr_y) * HA + int'(wr_x); m_wd = wr_pixel;
                end
            end
            m_fs = 0;
            if (pix_ce) begin
                e_out = e_rd;
                cur.vis = (mh < HA) && (mv < VA);
                cur.hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
                cur.vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
                cur.pix = 0;
                cur.known = 1;
                if (cur.vis) begin
                    m_ra = mv * HA + mh;
                    cur.pix = fb[m_ra];
                    // same-address read/write in one clock has no defined result
                    cur.known = fb_ok[m_ra] && !(m_we && m_wa == m_ra);
                end
                e_rd = cur;
                m_fs = (mh == HT - 1) && (mv == VT - 1);
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh++;
                end
            end
            if (m_we) begin
                fb[m_wa] = m_wd;
                fb_ok[m_wa] = 1;
            end
        end
    end

    // Per-clock comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("de", de, e_out.vis);
            if (e_out.known) chk("rgb", rgb, e_out.vis ? e_out.pix : 0);
            chk("hsync", hsync, e_out.hs ? 0 : 1);
            chk("vsync", vsync, e_out.vs ? 0 : 1);
            chk("vblank", vblank, mv >= VA);
            chk("frame_start", frame_start, m_fs);
            chk("clr_busy", clr_busy, m_clr_left > 0);
            chk("wr_ready", wr_ready, !(m_clr_left > 0));
        end
    end

    // ---------------- pixel-enable generator ----------------
    int ce_div = 1;
    int ce_cnt = 0;
    initial forever begin
        @(negedge clk);
        ce_cnt++;
        pix_ce = (ce_cnt % ce_div) == 0;
    end

    // ---------------- helpers ----------------
    bit [2:0] cap [N];

    task automatic wait_fs(input int bound);
        int c = 0;
        bit ok = 0;
        while (c < bound && !ok) begin
            @(negedge clk);
            c++;
            if (frame_start) ok = 1;
        end
        chk("frame_start_wait", ok, 1);
    endtask

    task automatic capture_frame();
        int n = 0;
        int c = 0;
        wait_fs(2000);
        while (n < N && c < 2000) begin
            @(negedge clk);
            c++;
            if (de) begin
                cap[n] = rgb;
                n++;
            end
        end
        chk("capture_count", n, N);
    endtask

    task automatic measure(input int exp_per, input int exp_hs, input int exp_de);
        int c = 0, hs_lo = 0, de_hi = 0;
        bit done = 0;
        wait_fs(2000);
        while (c < 4000 && !done) begin
            @(negedge clk);
            c++;
            if (frame_start) done = 1;
            else begin
                if (!hsync) hs_lo++;
                if (de) de_hi++;
            end
        end
        // the closing sample carries the frame_start pulse; fold its outputs in too
        if (!hsync) hs_lo++;
        if (de) de_hi++;
        chk("frame_period", c, exp_per);
        chk("hsync_low_clks", hs_lo, exp_hs);
        chk("de_high_clks", de_hi, exp_de);
    endtask

    task automatic do_write(input int x, input int y, input int p);
        wr_x = 4'(x); wr_y = 3'(y); wr_pixel = 3'(p); wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_clear(input int color);
        clr_color = 3'(color); clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
    endtask

    task automatic count_busy(input int exp);
        int c = 0;
        while (clr_busy && c < 200) begin
            c++;
            @(negedge clk);
        end
        chk("clr_busy_clks", c, exp);
    endtask

    task automatic wait_vblank();
        int c = 0;
        while (!vblank && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("vblank_wait", vblank, 1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int bad;
        repeat (3) @(negedge clk);
        chk("rst_rgb", rgb, 0);
        chk("rst_de", de, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_frame_start", frame_start, 0);
        srst = 1'b0;
        chk_en = 1;

        // clear to 0, then one pixel written during vertical blank
        start_clear(0);
        count_busy(32);
        wait_vblank();
        do_write(3, 2, 5);
        capture_frame();
        chk("pix_3_2", cap[19], 5);
        bad = 0;
        for (int i = 0; i < N; i++) if (i != 19 && cap[i] != 0) bad++;
        chk("other_pixels_zero", bad, 0);

        // timing at full pixel rate: 96-clk frame, 2 low per line, 8 x 4 visible
        measure(96, 16, 32);

        // clear to 6 while offering a write that must be ignored
        clr_color = 3'd6; clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        wr_x = 4'd1; wr_y = 3'd1; wr_pixel = 3'd3; wr_en = 1'b1;
        count_busy(32);
        wr_en = 1'b0;
        capture_frame();
        bad = 0;
        for (int i = 0; i < N; i++) if (cap[i] != 6) bad++;
        chk("all_pixels_six", bad, 0);

        // out-of-range writes, then a clear to 7 aborted by reset at address 10
        do_write(8, 0, 1);
        do_write(0, 4, 1);
        start_clear(7);
        repeat (10) @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("abort_clr_busy", clr_busy, 0);
        chk("abort_wr_ready", wr_ready, 1);
        capture_frame();
        bad = 0;
        for (int i = 0; i < N; i++) if (cap[i] != ((i < 10) ? 7 : 6)) bad++;
        chk("partial_clear", bad, 0);
        chk("alias_pixel_8", cap[8], 7);
        chk("alias_pixel_10", cap[10], 6);
        chk("alias_pixel_0", cap[0], 7);

        // sparse pixel enable: everything stretched by 4
        ce_div = 4;
        measure(384, 64, 128);
        ce_div = 1;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
